// File: rtl/tdc_interval_gen_if.sv
// tdc_interval_gen_if: request and pulse bundle between a stimulus source and tdc_interval_gen.
interface tdc_interval_gen_if #(parameter int size_of_TDC = 9);
    logic                   enable;
    logic                   load;
    logic [size_of_TDC-1:0] interval_in;
    logic                   start_out;
    logic                   stop_out;
    logic                   busy;
    logic                   done;
    logic [size_of_TDC-1:0] interval_out;
    logic                   err_zero;
    logic                   overrun;
    modport master (
        output enable, load, interval_in,
        input  start_out, stop_out, busy, done, interval_out, err_zero, overrun
    );
    modport slave (
        input  enable, load, interval_in,
        output start_out, stop_out, busy, done, interval_out, err_zero, overrun
    );
endinterface

// File: rtl/tdc_interval_gen.sv
// tdc_interval_gen: emits START then STOP exactly interval cycles apart for driving TDC inputs.
// Optional macro TDC_GEN_PRBS_EN takes intervals from a 9-bit LFSR instead of interval_in.
module tdc_interval_gen #(
    parameter int size_of_TDC = 9,
    parameter int pulse_width = 2,
    parameter int min_gap     = 4
) (
    input logic              clk,
    input logic              reset,
    tdc_interval_gen_if.slave bus
);
    localparam int CW = size_of_TDC + 1;
    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n, last;
    logic [size_of_TDC-1:0] interval_q, interval_n, req;
    logic                   start_q, stop_q, err_q, ovr_q;
    logic                   start_n, stop_n, err_n, ovr_n, accept;
`ifdef TDC_GEN_PRBS_EN
    logic [8:0] lfsr;
    assign req = size_of_TDC'(lfsr);
    always_ff @(posedge clk)
        if (reset) lfsr <= 9'h1FF;
        else if (accept) lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
`else
    assign req = bus.interval_in;
`endif
    assign accept = state == IDLE && bus.load && bus.enable && req != '0;
    assign last   = {1'b0, interval_q} + CW'(pulse_width - 1);
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CW'(1);
        interval_n = interval_q;
        err_n      = 1'b0;
        ovr_n      = ovr_q | (bus.load && state != IDLE);
        case (state)
            IDLE: begin
                cnt_n = '0;
                err_n = bus.load && bus.enable && req == '0;
                if (accept) begin
                    state_n    = RUN;
                    interval_n = req;
                    ovr_n      = 1'b0;
                end
            end
            RUN: if (cnt == last) begin
                state_n = GAP;
                cnt_n   = '0;
            end
            GAP: state_n = cnt == CW'(min_gap - 1) ? DONE : GAP;
            default: state_n = IDLE;
        endcase
        if (!bus.enable && state != IDLE) begin
            state_n = IDLE;
            cnt_n   = '0;
        end
        // outputs are registered, so they are decoded from the next-cycle count
        start_n = state_n == RUN && cnt_n < CW'(pulse_width);
        stop_n  = state_n == RUN && cnt_n >= {1'b0, interval_n}
                  && cnt_n <= {1'b0, interval_n} + CW'(pulse_width - 1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            interval_q <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            interval_q <= interval_n;
            start_q    <= start_n;
            stop_q     <= stop_n;
            err_q      <= err_n;
            ovr_q      <= ovr_n;
        end
    end
    assign bus.start_out    = start_q;
    assign bus.stop_out     = stop_q;
    assign bus.busy         = state != IDLE;
    assign bus.done         = state == DONE;
    assign bus.interval_out = interval_q;
    assign bus.err_zero     = err_q;
    assign bus.overrun      = ovr_q;
endmodule
